// File: rtl/pipe_stage_reg.sv
// Generic pipeline register stage: valid/ready handshake, stall, flush, bubble insertion, stall counter.
// Define SKID_BUF_EN to add a one-entry skid register and break the out_ready -> in_ready path.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  stall_cnt_o,
  input  logic              cnt_clr_i
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              in_xfer, out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;

`ifdef SKID_BUF_EN
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  assign in_ready = !skid_valid_q && !stall_i && !flush_i;

  // Output register drains the skid entry first; blocked inputs park in the skid.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      out_data_d   = NOP_VALUE;
      skid_valid_d = 1'b0;
      skid_data_d  = NOP_VALUE;
    end else if (!stall_i) begin
      if (!out_valid_q || out_ready) begin
        if (skid_valid_q) begin
          out_valid_d  = 1'b1;
          out_data_d   = skid_data_q;
          skid_valid_d = 1'b0;
          skid_data_d  = NOP_VALUE;
        end else if (in_xfer) begin
          out_valid_d = 1'b1;
          out_data_d  = in_data;
        end else if (out_xfer) begin
          out_valid_d = 1'b0;
          out_data_d  = NOP_VALUE;
        end
      end else if (in_xfer) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= NOP_VALUE;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  assign in_ready = !flush_i && !stall_i && (!out_valid_q || out_ready);

  // Flush > stall > load > bubble > hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
      out_data_d  = NOP_VALUE;
    end else if (!stall_i) begin
      if (in_xfer) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else if (out_xfer) begin
        out_valid_d = 1'b0;
        out_data_d  = NOP_VALUE;
      end
    end
  end
`endif

  // Saturating blocked-cycle counter; clear wins over increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr_i) begin
      stall_cnt_d = '0;
    end else if ((stall_i || (out_valid_q && !out_ready)) && !flush_i
                 && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= NOP_VALUE;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (CNT_W=4); covers both builds of SKID_BUF_EN.
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              stall_i;
  logic              flush_i;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic              cnt_clr_i;

  int n_assert = 0;
  int n_fail   = 0;

  pipe_stage_reg #(.DATA_W(DATA_W), .NOP_VALUE('0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_i(stall_i), .flush_i(flush_i),
    .stall_cnt_o(stall_cnt_o), .cnt_clr_i(cnt_clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    stall_i = 1'b0; flush_i = 1'b0; cnt_clr_i = 1'b0;
    repeat (2) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_cnt", 32'(stall_cnt_o), 32'd0);
    @(negedge clk); rst = 1'b1; #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back stream with no gaps, then a bubble
    in_valid = 1'b1; out_ready = 1'b1; in_data = 32'h11;
    tick(); chk("str_v0", 32'(out_valid), 32'd1); chk("str_d0", out_data, 32'h11);
    in_data = 32'h22;
    tick(); chk("str_v1", 32'(out_valid), 32'd1); chk("str_d1", out_data, 32'h22);
    in_data = 32'h33;
    tick(); chk("str_v2", 32'(out_valid), 32'd1); chk("str_d2", out_data, 32'h33);
    in_valid = 1'b0;
    tick(); chk("str_bub_v", 32'(out_valid), 32'd0); chk("str_bub_d", out_data, 32'd0);
    chk("str_cnt", 32'(stall_cnt_o), 32'd0);

    // Stall holds output despite out_ready
    in_valid = 1'b1; in_data = 32'h44;
    tick(); chk("hold_d", out_data, 32'h44);
    in_valid = 1'b0; stall_i = 1'b1; #1;
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_v", 32'(out_valid), 32'd1);
      chk("stall_d", out_data, 32'h44);
    end
    chk("stall_cnt3", 32'(stall_cnt_o), 32'd3);

    // Flush discards contents and does not capture the input
    stall_i = 1'b0; flush_i = 1'b1; in_valid = 1'b1; in_data = 32'h55; #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("flush_v", 32'(out_valid), 32'd0); chk("flush_d", out_data, 32'd0);
    chk("flush_cnt", 32'(stall_cnt_o), 32'd3);
    flush_i = 1'b0; in_valid = 1'b0;
    tick();
    chk("flush_nocap_v", 32'(out_valid), 32'd0); chk("flush_nocap_d", out_data, 32'd0);

    // Counter clear and saturation under backpressure
    cnt_clr_i = 1'b1;
    tick(); chk("clr_cnt", 32'(stall_cnt_o), 32'd0);
    cnt_clr_i = 1'b0; in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b0;
    tick(); chk("bp_load_d", out_data, 32'h77); chk("bp_cnt0", 32'(stall_cnt_o), 32'd0);
    in_valid = 1'b0;
    repeat (5) tick();
    chk("bp_cnt5", 32'(stall_cnt_o), 32'd5);
    repeat (15) tick();
    chk("bp_cnt_sat", 32'(stall_cnt_o), 32'd15);
    chk("bp_hold_d", out_data, 32'h77);
`ifdef SKID_BUF_EN
    chk("bp_in_ready", 32'(in_ready), 32'd1);
`else
    chk("bp_in_ready", 32'(in_ready), 32'd0);
`endif
    cnt_clr_i = 1'b1;
    tick(); chk("sat_clr", 32'(stall_cnt_o), 32'd0);
    cnt_clr_i = 1'b0;

    // Push 0x66 while the output is blocked, then drain
    in_valid = 1'b1; in_data = 32'h66;
`ifdef SKID_BUF_EN
    tick();
    in_valid = 1'b0; #1;
    chk("skid_in_ready", 32'(in_ready), 32'd0);
    chk("skid_old_d", out_data, 32'h77);
    out_ready = 1'b1;
    tick();
`else
    tick();
    chk("base_old_d", out_data, 32'h77);
    out_ready = 1'b1; #1;
    chk("base_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
`endif
    chk("drain_v", 32'(out_valid), 32'd1); chk("drain_d", out_data, 32'h66);
    tick();
    chk("drain_bub_v", 32'(out_valid), 32'd0); chk("drain_bub_d", out_data, 32'd0);
    chk("drain_in_ready", 32'(in_ready), 32'd1);

    // Asynchronous reset mid-transfer, then idle first edge
    in_valid = 1'b1; in_data = 32'h99; out_ready = 1'b0;
    tick(); chk("pre_rst_d", out_data, 32'h99);
    #2 rst = 1'b0; #1;
    chk("arst_v", 32'(out_valid), 32'd0); chk("arst_d", out_data, 32'd0);
    chk("arst_cnt", 32'(stall_cnt_o), 32'd0);
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    tick();
    chk("post_rst_v", 32'(out_valid), 32'd0); chk("post_rst_cnt", 32'(stall_cnt_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
